rom_pattern_reader: RTL and testbench
=====================================

# rom_pattern_reader

Sequencer and bit packer that drives the 1-bit, 128-entry pattern ROM and consumes its registered output. On a start pulse it sweeps ROM addresses 0..127 once and packs the returned bits MSB-first into sixteen 8-bit words. Words are presented on a valid/ready stream to the downstream consumer. The block sits between the control logic (start/done) and the pattern ROM.

## Interface
Parameters:
- ADDR_W, 7, ROM address width
- DEPTH, 128, number of ROM entries swept; must be a multiple of WORD_W
- WORD_W, 8, packed word width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- busy  out  1  high from the first address issue until the last word is accepted
- done  out  1  one-cycle pulse after the last word handshake
- rom_address  out  ADDR_W  registered address to the ROM
- rom_q  in  1  ROM data; the ROM is registered, so rom_q reflects the rom_address of the previous cycle
- word_data  out  WORD_W  packed word; bit 7 holds address 8k, bit 0 holds address 8k+7
- word_valid  out  1  word_data holds an unaccepted word
- word_ready  in  1  consumer accepts when word_valid && word_ready at a rising edge
- word_last  out  1  high together with word_valid for word 15 only

## Operation
- Reset values: busy=0, done=0, rom_address=0, word_data=0, word_valid=0, word_last=0. The FSM resets to IDLE and the pending flag clears. Reset mid-sweep aborts the sweep, and no partial word is emitted afterwards.
- FSM states:
  - IDLE: start=1 leads to SCAN, with rom_address=0 issued and pend=1.
  - SCAN: issues one address per cycle. After address 127 is issued, the FSM moves to FLUSH.
  - FLUSH: waits for the last capture and the last handshake, then moves to DONE.
  - DONE: done=1 for one cycle, then the FSM returns to IDLE.
- pend marks that rom_q is valid this cycle for the address issued last cycle. A bit is captured into the 7-bit shift register whenever pend=1.
- Capturing bit index 7 (address[2:0]==7) loads {shift[6:0], rom_q} into word_data. The same edge sets word_valid and sets word_last if address==127.
- Issue rule for an address a with a[2:0]==7: it is issued only in a cycle where !word_valid || word_ready. Otherwise rom_address holds its current value and pend is cleared (stall). This guarantees the output slot is free when the bit for a arrives. Bits are never lost or duplicated.
- Addresses with a[2:0]!=7 are issued unconditionally while in SCAN.
- word_valid clears on a handshake unless a new word loads on the same edge.
- word_data and word_last are stable while word_valid && !word_ready.
- start in any state other than IDLE is ignored. start coincident with reset deassertion is ignored.
- After the sweep, rom_address returns to 0.

## Timing
- Cycle 0 has start=1. rom_address=0 and busy=1 from cycle 1. rom_q(0) is valid in cycle 2.
- With word_ready tied high:
  - Address a is driven in cycle a+1.
  - Word k has word_valid=1 in cycle 8k+10.
  - Word 15 appears in cycle 130 with word_last=1.
  - In cycle 131: done=1, busy=0, FSM in DONE. The FSM is in IDLE in cycle 132.
- Throughput is 1 bit/cycle with no bubbles when word_ready=1 in the cycle each index-7 address is due.
- Each stall cycle delays all later addresses and words by exactly one cycle.
- A start accepted in IDLE at cycle n puts address 0 out in cycle n+1.

## Structure
- A shared package fams_rom_pkg holds:
  - ROM_ADDR_W=7, ROM_DEPTH=128, PACK_W=8, WORDS=ROM_DEPTH/PACK_W
  - the FSM state enum (IDLE, SCAN, FLUSH, DONE)
- One sub-module, bit_packer, contains the 7-bit shift register, the output word register, word_valid/word_last, and the handshake logic. Its inputs are pend, rom_q, the bit index and the last flag, and it exports slot_free.
- The top level holds the FSM, the address counter, the issue/stall logic and done/busy.

## Test plan
- Free-running sweep (word_ready=1) against the pattern ROM: 16 words arrive in cycles 10, 18, ... 130. Words 3..11 equal 0x2C,0x6E,0x6E,0x0E,0x1C,0x30,0x3A,0x7E,0x5C, and all others are 0x00. word_last is high only in cycle 130, done pulses in cycle 131.
- word_ready held low from cycle 10 to 29: word 0 is held stable, and address 15 is not issued until word_ready rises. Word 1 appears one cycle after the capture of bit 15. All 16 words match the free-running run, and done is delayed by exactly the stall count.
- word_ready toggling 1/0 every cycle: no word is lost or duplicated, word_data is stable while stalled, and the 16-word sequence is identical.
- start pulsed again at cycles 5 and 60 during a sweep: both are ignored, exactly 16 words are emitted, and done pulses once.
- reset asserted asynchronously in cycle 50 (mid-word 5): all outputs read 0 immediately. A new start then produces a complete, correct 16-word sweep with no residue of the aborted one.
- Back-to-back sweeps: start in the first IDLE cycle after done, i.e. cycle 132. Address 0 is driven in cycle 133, and both sweeps produce identical data.

Source files
------------

// File: rtl/fams_rom_pkg.sv
// Shared constants and FSM encoding for the pattern ROM reader.
package fams_rom_pkg;
    localparam int ROM_ADDR_W = 7;
    localparam int ROM_DEPTH  = 128;
    localparam int PACK_W     = 8;
    localparam int WORDS      = ROM_DEPTH / PACK_W;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
endpackage

// File: rtl/bit_packer.sv
// Packs captured ROM bits MSB-first into words and holds each word on a
// valid/ready stream until the consumer accepts it.
module bit_packer #(
    parameter int WORD_W = 8,
    parameter int IDX_W  = $clog2(WORD_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pend,
    input  logic              rom_q,
    input  logic [IDX_W-1:0]  bit_index,
    input  logic              last,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              word_last,
    output logic              slot_free
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-2:0] shift;
    logic              cap_word;

    assign cap_word  = pend && (bit_index == LAST_IDX);
    assign slot_free = !word_valid || word_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift      <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
        end else begin
            if (pend)
                shift <= {shift[WORD_W-3:0], rom_q};
            // The issuer only lets an index-7 address out when the slot
            // will be free, so a load never overwrites an unaccepted word.
            if (cap_word) begin
                word_data  <= {shift, rom_q};
                word_valid <= 1'b1;
                word_last  <= last;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
                word_last  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/rom_pattern_reader.sv
// Sweeps the registered pattern ROM once per start and streams the packed
// words; stalls the address that completes a word while the output is full.
module rom_pattern_reader
    import fams_rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DEPTH  = ROM_DEPTH,
    parameter int WORD_W = PACK_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_address,
    input  logic              rom_q,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last
);
    localparam int               IDX_W     = $clog2(WORD_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt, next_addr, pend_addr;
    logic              iss, iss_nxt, pend, armed, slot_free;

    assign next_addr = rom_address + ADDR_W'(1);

    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_address;
        iss_nxt   = 1'b0;
        case (state)
            IDLE: if (start && armed) begin
                state_nxt = SCAN;
                addr_nxt  = '0;
                iss_nxt   = 1'b1;
            end
            SCAN: if (rom_address == LAST_ADDR) begin
                state_nxt = FLUSH;
                addr_nxt  = '0;
            end else if (next_addr[IDX_W-1:0] != LAST_IDX || slot_free) begin
                addr_nxt = next_addr;
                iss_nxt  = 1'b1;
            end
            FLUSH: if (word_valid && word_ready && word_last)
                state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // iss: rom_address is a fresh issue this cycle; pend: its data is on rom_q.
    // armed keeps a start that coincides with reset release from being taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rom_address <= '0;
            iss         <= 1'b0;
            pend        <= 1'b0;
            pend_addr   <= '0;
            armed       <= 1'b0;
        end else begin
            state       <= state_nxt;
            rom_address <= addr_nxt;
            iss         <= iss_nxt;
            pend        <= iss;
            pend_addr   <= rom_address;
            armed       <= 1'b1;
        end
    end

    assign busy = (state == SCAN) || (state == FLUSH);
    assign done = (state == DONE);

    bit_packer #(.WORD_W(WORD_W), .IDX_W(IDX_W)) u_packer (
        .clock      (clock),
        .reset      (reset),
        .pend       (pend),
        .rom_q      (rom_q),
        .bit_index  (pend_addr[IDX_W-1:0]),
        .last       (pend_addr == LAST_ADDR),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_last  (word_last),
        .slot_free  (slot_free)
    );
endmodule

// File: tb/tb_rom_pattern_reader.sv
// Drives rom_pattern_reader against a behavioural ROM and checks words,
// handshake stability and sweep timing from the packing rules.
module tb_rom_pattern_reader;
    logic       clock = 1'b0;
    logic       reset, start, rom_q, word_ready;
    logic       busy, done, word_valid, word_last;
    logic [6:0] rom_address;
    logic [7:0] word_data;

    logic       rom [128];
    logic [7:0] exp_w [16];
    int nvec = 0;
    int nerr = 0;

    localparam logic [7:0] PAT [16] = '{8'h00, 8'h00, 8'h00, 8'h2C, 8'h6E, 8'h6E, 8'h0E, 8'h1C,
                                        8'h30, 8'h3A, 8'h7E, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clock = ~clock;
    always @(posedge clock) rom_q <= rom[rom_address];

    rom_pattern_reader dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .rom_address(rom_address), .rom_q(rom_q), .word_data(word_data),
        .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_pattern();
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 8; j++) rom[8*k+j] = PAT[k][7-j];
            exp_w[k] = PAT[k];
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < 128; i++) rom[i] = 1'($urandom_range(0, 1));
        for (int k = 0; k < 16; k++) begin
            int v = 0;
            for (int j = 0; j < 8; j++) v = v * 2 + int'(rom[8*k+j]);
            exp_w[k] = 8'(v);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0: return 1'b1;
            1: return !(cyc >= 10 && cyc <= 29);
            2: return (cyc % 2) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // Cycle 0 is the cycle start is high. exp_done < 0: timing not fixed,
    // done must follow the last handshake by one cycle.
    task automatic sweep(input int mode, input bit extra, input int exp_done, input int abort_at);
        int cyc = 0, nw = 0, ndone = 0, last_hs = -1, exp_d;
        bit stalled = 0, held_last = 0;
        logic [7:0] held = '0;
        start = 1'b1;
        word_ready = ready_for(mode, 0);
        while (1) begin
            tick();
            cyc++;
            start = extra && (cyc == 5 || cyc == 60);
            word_ready = ready_for(mode, cyc);
            if (cyc == abort_at) begin
                #2 reset = 1'b1;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_addr", rom_address, 0);
                chk("abort_data", word_data, 0);
                chk("abort_valid", word_valid, 0);
                chk("abort_last", word_last, 0);
                tick(); tick();
                reset = 1'b0;
                tick(); tick();
                return;
            end
            exp_d = (exp_done > 0) ? exp_done : ((last_hs >= 0) ? last_hs + 1 : -1);
            if (stalled) begin
                chk("hold_valid", word_valid, 1);
                chk("hold_data", word_data, held);
                chk("hold_last", word_last, held_last);
            end
            chk("busy", busy, (exp_d < 0) || (cyc < exp_d));
            chk("done", done, cyc == exp_d);
            if (word_valid && word_ready) begin
                if (nw < 16) begin
                    chk("word", word_data, exp_w[nw]);
                    chk("word_last", word_last, nw == 15);
                    if (mode == 0) chk("word_cyc", cyc, 8*nw + 10);
                    if (mode == 1) chk("word_cyc", cyc, (nw == 0) ? 30 : 8*nw + 25);
                end else
                    chk("extra_word", nw, 15);
                nw++;
                if (nw == 16) last_hs = cyc;
            end
            stalled   = word_valid && !word_ready;
            held      = word_data;
            held_last = word_last;
            if (done) ndone++;
            if (mode == 0 && cyc == 1)   chk("addr0", rom_address, 0);
            if (mode == 0 && cyc == 64)  chk("addr63", rom_address, 63);
            if (mode == 0 && cyc == 128) chk("addr127", rom_address, 127);
            if (mode == 1 && cyc == 30)  chk("addr_stall", rom_address, 14);
            if (mode == 1 && cyc == 31)  chk("addr15", rom_address, 15);
            if (exp_d > 0 && cyc == exp_d + 1) begin
                chk("addr_idle", rom_address, 0);
                break;
            end
            if (cyc > 700) begin
                chk("timeout", 0, 1);
                break;
            end
        end
        chk("ndone", ndone, 1);
        chk("nwords", nw, 16);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        word_ready = 1'b0;
        load_pattern();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_address, 0);
        chk("rst_data", word_data, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_last", word_last, 0);
        tick();
        reset = 1'b0;
        tick(); tick();

        sweep(0, 0, 131, -1);   // free-running
        sweep(0, 0, 131, -1);   // back-to-back, start in first idle cycle
        tick(); tick();
        sweep(1, 0, 146, -1);   // consumer stalled cycles 10..29
        tick();
        sweep(2, 0, -1, -1);    // ready toggling
        tick();
        sweep(0, 1, 131, -1);   // extra starts mid-sweep ignored
        tick();
        sweep(0, 0, -1, 50);    // asynchronous reset mid-word 5
        sweep(0, 0, 131, -1);   // clean sweep after abort
        load_random();
        tick();
        sweep(3, 0, -1, -1);
        sweep(0, 0, 131, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
